fp_normalize_stage: RTL and testbench

- Post-add/subtract normalization stage of the parametrizable FPU.
- Takes the raw mantissa sum (with carry bit), exponent and sign.
- Finds the leading one, computes the shift distance, drives a left/right normalising shift and adjusts the exponent.
- Two-stage valid/ready pipeline; output feeds the rounding stage.

---
 rtl/fpu_pkg.sv | 13 +
 rtl/fp_normalize_stage_lzc.sv | 17 +
 rtl/fp_normalize_stage.sv | 122 ++++++++++++
 tb/tb_fp_normalize_stage.sv | 135 +++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU types and sizing helpers.
//   shamt_w(size)      width of the shifter's shift-distance port
//   norm_case_e        normalisation case decoded in the first stage
//   exp_all_ones(w)    all-ones exponent (infinity) for a w-bit field
package fpu_pkg;
  function automatic int shamt_w(input int size);
    return $clog2(size) + 2;
  endfunction
  typedef enum logic [1:0] {NORM_ZERO, NORM_CARRY, NORM_LEFT, NORM_DENORM} norm_case_e;
  function automatic logic [31:0] exp_all_ones(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction
endpackage

// File: rtl/fp_normalize_stage_lzc.sv
// leading_zero_count: combinational leading-zero counter.
//   i_data  [SIZE-1:0]        value to scan
//   o_count [$clog2(SIZE):0]  leading zeros of i_data; SIZE when i_data is 0
module leading_zero_count #(
  parameter int SIZE = 64
) (
  input  logic [SIZE-1:0]         i_data,
  output logic [$clog2(SIZE):0]   o_count
);
  localparam int CW = $clog2(SIZE) + 1;
  // Scanning upward lets the highest set bit have the last word.
  always_comb begin
    o_count = CW'(SIZE);
    for (int i = 0; i < SIZE; i++)
      if (i_data[i]) o_count = CW'(SIZE - 1 - i);
  end
endmodule

// File: rtl/fp_normalize_stage.sv
// fp_normalize_stage: two-stage valid/ready normaliser after the FPU adder.
//   i_clk, i_rst_n           clock, async active-low reset
//   i_valid/o_ready          input handshake; o_ready is combinational from i_ready
//   i_mant/i_exp/i_sign      raw sum (bit SIZE = carry), biased exponent, sign
//   o_valid/i_ready          output handshake
//   o_mant/o_exp/o_sign      normalised mantissa, adjusted exponent, sign
//   o_zero/o_denorm/o_ovf    exact zero, subnormal, overflow to infinity
//   o_sticky                 bit lost by the carry right shift (FP_NORM_STICKY_EN only)
module fp_normalize_stage
  import fpu_pkg::*;
#(
  parameter int SIZE  = 64,
  parameter int EXP_W = 11
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [SIZE:0]    i_mant,
  input  logic [EXP_W-1:0] i_exp,
  input  logic             i_sign,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [SIZE-1:0]  o_mant,
  output logic [EXP_W-1:0] o_exp,
  output logic             o_sign,
  output logic             o_zero,
  output logic             o_denorm,
  output logic             o_ovf
`ifdef FP_NORM_STICKY_EN
  ,
  output logic             o_sticky
`endif
);
  localparam int LZW = $clog2(SIZE) + 1;
  localparam int SW  = shamt_w(SIZE);
  localparam int EW  = EXP_W + 1;
  localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(exp_all_ones(EXP_W));
  logic [LZW-1:0] lz;
  leading_zero_count #(.SIZE(SIZE)) u_lzc (.i_data(i_mant[SIZE-1:0]), .o_count(lz));
  logic             v1_q, v2_q, s1_adv, s2_adv;
  logic [SIZE:0]    m1_q;
  logic [EXP_W-1:0] e1_q;
  logic             s1_q;
  logic [LZW-1:0]   lz1_q;
  norm_case_e       c1_q, case_d;
  logic [SIZE-1:0]  mant_q, mant_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             sign_q, zero_q, denorm_q, ovf_q, ovf_d;
  logic [EW-1:0]    e_inc, e_sub;
  logic [SW-1:0]    sh;
  logic             right;
  assign s2_adv  = !v2_q || i_ready;
  assign s1_adv  = !v1_q || s2_adv;
  assign o_ready = s1_adv;
  assign case_d = i_mant == '0 ? NORM_ZERO :
                  i_mant[SIZE] ? NORM_CARRY :
                  {1'b0, i_exp} > EW'(lz) ? NORM_LEFT : NORM_DENORM;
  // Exponent math is one bit wider so overflow and underflow are visible.
  always_comb begin
    right  = c1_q == NORM_CARRY;
    e_inc  = {1'b0, e1_q} + EW'(1);
    e_sub  = {1'b0, e1_q} - EW'(lz1_q);
    ovf_d  = right && e_inc >= {1'b0, EXP_ONES};
    sh     = right ? SW'(1) :
             c1_q == NORM_LEFT ? SW'(lz1_q) :
             c1_q == NORM_DENORM && e1_q != '0 ? SW'(e1_q - EXP_W'(1)) : '0;
    mant_d = ovf_d ? '0 : SIZE'(right ? m1_q >> sh : m1_q << sh);
    exp_d  = ovf_d ? EXP_ONES :
             right ? e_inc[EXP_W-1:0] :
             c1_q == NORM_LEFT && !e_sub[EW-1] ? e_sub[EXP_W-1:0] : '0;
  end
`ifdef FP_NORM_STICKY_EN
  logic sticky_q;
  assign o_sticky = sticky_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) sticky_q <= 1'b0;
    else if (s2_adv && v1_q) sticky_q <= right && m1_q[0];
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      m1_q     <= '0;
      e1_q     <= '0;
      s1_q     <= 1'b0;
      lz1_q    <= '0;
      c1_q     <= NORM_ZERO;
      mant_q   <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (s1_adv) v1_q <= i_valid;
      if (s1_adv && i_valid) begin
        m1_q  <= i_mant;
        e1_q  <= i_exp;
        s1_q  <= i_sign;
        lz1_q <= lz;
        c1_q  <= case_d;
      end
      if (s2_adv) v2_q <= v1_q;
      if (s2_adv && v1_q) begin
        mant_q   <= mant_d;
        exp_q    <= exp_d;
        sign_q   <= s1_q;
        zero_q   <= c1_q == NORM_ZERO;
        denorm_q <= c1_q == NORM_DENORM;
        ovf_q    <= ovf_d;
      end
    end
  end
  assign o_valid  = v2_q;
  assign o_mant   = mant_q;
  assign o_exp    = exp_q;
  assign o_sign   = sign_q;
  assign o_zero   = zero_q;
  assign o_denorm = denorm_q;
  assign o_ovf    = ovf_q;
endmodule

// File: tb/tb_fp_normalize_stage.sv
// tb_fp_normalize_stage: directed table-driven bench for fp_normalize_stage (SIZE=8, EXP_W=5).
module tb_fp_normalize_stage;
  localparam int SIZE = 8, EXP_W = 5;
`ifdef FP_NORM_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, i_valid, o_ready, i_sign, o_valid, i_ready;
  logic [SIZE:0] i_mant;
  logic [EXP_W-1:0] i_exp, o_exp;
  logic [SIZE-1:0] o_mant;
  logic o_sign, o_zero, o_denorm, o_ovf, sticky_w;
  fp_normalize_stage #(.SIZE(SIZE), .EXP_W(EXP_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_mant(i_mant), .i_exp(i_exp), .i_sign(i_sign), .o_valid(o_valid),
    .i_ready(i_ready), .o_mant(o_mant), .o_exp(o_exp), .o_sign(o_sign),
    .o_zero(o_zero), .o_denorm(o_denorm), .o_ovf(o_ovf)
`ifdef FP_NORM_STICKY_EN
    , .o_sticky(sticky_w)
`endif
  );
`ifndef FP_NORM_STICKY_EN
  assign sticky_w = 1'b0;
`endif
  typedef struct {
    logic [8:0] mant;
    logic [4:0] exp;
    logic       sign;
    logic [7:0] r_mant;
    logic [4:0] r_exp;
    logic       r_zero, r_den, r_ovf, r_stk;
  } vec_t;
  vec_t tbl[12];
  int n_vec = 0, n_bad = 0;
  function automatic logic [17:0] outs();
    return {o_mant, o_exp, o_sign, o_zero, o_denorm, o_ovf, sticky_w};
  endfunction
  function automatic logic [17:0] want(input int i);
    return {tbl[i].r_mant, tbl[i].r_exp, tbl[i].sign, tbl[i].r_zero, tbl[i].r_den, tbl[i].r_ovf, tbl[i].r_stk & STK};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input int i);
    i_mant = tbl[i].mant;
    i_exp  = tbl[i].exp;
    i_sign = tbl[i].sign;
  endtask
  task automatic run_vec(input int i, input string nm);
    @(posedge clk); #1;
    drive(i);
    i_valid = 1'b1;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk({nm, " early"}, 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    chk({nm, " valid"}, 32'(o_valid), 32'd1);
    chk(nm, 32'(outs()), 32'(want(i)));
  endtask
  int sent, recv;
  logic saw_stall, held;
  logic [17:0] prev;
  initial begin
    tbl[0]  = '{9'h160, 5'd10, 1'b1, 8'hB0, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{9'h013, 5'd10, 1'b0, 8'h98, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{9'h013, 5'd3,  1'b0, 8'h4C, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{9'h013, 5'd0,  1'b1, 8'h13, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{9'h000, 5'd17, 1'b1, 8'h00, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{9'h100, 5'd30, 1'b0, 8'h00, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{9'h080, 5'd5,  1'b0, 8'h80, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{9'h001, 5'd8,  1'b1, 8'h80, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{9'h001, 5'd7,  1'b0, 8'h40, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{9'h1FF, 5'd29, 1'b0, 8'hFF, 5'd30, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{9'h101, 5'd30, 1'b1, 8'h00, 5'd31, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{9'h002, 5'd1,  1'b0, 8'h02, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0};
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_mant = '0; i_exp = '0; i_sign = 1'b0;
    #23;
    chk("reset valid", 32'(o_valid), 32'd0);
    chk("reset data", 32'(outs()), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("reset ready", 32'(o_ready), 32'd1);
    for (int i = 0; i < 12; i++) run_vec(i, $sformatf("vec%0d", i));
    // Backpressure: 5 beats back to back, downstream stalled in cycles 3..6.
    sent = 0; recv = 0; saw_stall = 1'b0; held = 1'b0; prev = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      i_valid = sent < 5;
      if (sent < 5) drive(sent);
      i_ready = !(c >= 3 && c <= 6);
      @(negedge clk);
      if (!o_ready) saw_stall = 1'b1;
      if (held) chk($sformatf("hold c%0d", c), 32'(outs()), 32'(prev));
      if (o_valid && i_ready) begin
        chk($sformatf("bp beat%0d", recv), 32'(outs()), 32'(want(recv)));
        recv++;
      end
      held = o_valid && !i_ready;
      prev = outs();
      if (i_valid && o_ready) sent++;
    end
    i_valid = 1'b0;
    chk("bp count", 32'(recv), 32'd5);
    chk("bp stall", 32'(saw_stall), 32'd1);
    // Reset with two beats in flight.
    i_ready = 1'b1;
    @(posedge clk); #1;
    drive(1); i_valid = 1'b1;
    @(posedge clk); #1;
    drive(2);
    @(posedge clk); #1;
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst async valid", 32'(o_valid), 32'd0);
    #3 rst_n = 1'b1;
    recv = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (o_valid) recv++;
    end
    chk("rst no stale", 32'(recv), 32'd0);
    run_vec(7, "post rst");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
